bcd_modn_cnt: RTL and testbench
===============================

Name: bcd_modn_cnt

Overview:
Parametrised two-digit BCD modulo-N counter, the generalised successor of the fixed mod-60 seconds/minutes stage. Chains via enin/enout to build seconds, minutes and hours (mod 60, mod 60, mod 24) or any modulus 2..100 in the clock datapath. Adds a parallel BCD preset load with range checking, a registered wrap pulse, and an optional count-down direction.

Parameters:
MODULO, 60, count modulus; legal range 2..100; value sequence 0..MODULO-1
INIT_VAL, 0, value taken on rst/clr (binary 0..MODULO-1, stored as BCD)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
clr  in  1  synchronous clear to INIT_VAL
enin  in  1  count enable (carry-in from the previous stage)
dir  in  1  0 = up, 1 = down (honoured only with BCD_CNT_DOWN_EN)
load  in  1  synchronous preset strobe
ld_ones  in  4  BCD preset, ones digit
ld_tens  in  4  BCD preset, tens digit
ones  out  4  ones digit, BCD 0..9, registered
tens  out  4  tens digit, BCD 0..9, registered
enout  out  1  combinational carry/borrow to the next stage
wrap  out  1  registered one-cycle pulse after a wrap occurred
load_err  out  1  registered one-cycle pulse after a rejected load

Behaviour:
- Value V = 10*tens + ones; always satisfies 0 <= V <= MODULO-1; both digits always legal BCD.
- Reset (rst=1): ones/tens = INIT_VAL digits, wrap = 0, load_err = 0.
- Priority per cycle: rst > clr > load > enin. Lower-priority actions in the same cycle are discarded.
- clr: ones/tens = INIT_VAL digits; wrap and load_err = 0 next cycle.
- load, valid (ld_ones <= 9, ld_tens <= 9, 10*ld_tens + ld_ones < MODULO): V takes the preset next cycle; load_err = 0.
- load, invalid: V = 0 next cycle; load_err = 1 for exactly one cycle.
- Up count (enin=1, dir ignored or 0): ones 9 -> 0 with tens+1; otherwise ones+1. When V == MODULO-1, V -> 0 (both digits 0) regardless of the ones value.
- Terminal detection uses the full value, not the ones digit alone (e.g. MODULO=24: 23 -> 00; MODULO=100: 99 -> 00).
- enout = enin & ~rst & ~clr & ~load & (V == terminal), where terminal = MODULO-1 (up) or 0 (down). Zero-latency, so chained stages advance in the same cycle.
- wrap: registered copy of enout; high the cycle after a wrap.
- enin=0 with no other action: hold all state; wrap and load_err return to 0.
- Latency: every register update is visible one cycle after the triggering edge; enout has no latency.
- Width rules: internal compare on a 7-bit binary value (max 99); no carry beyond tens.
- MODULO outside 2..100 or INIT_VAL >= MODULO: elaboration error via generate-time check.

Optional Feature:
BCD_CNT_DOWN_EN
- Defined: dir=1 counts down. ones 0 -> 9 with tens-1; V == 0 -> MODULO-1 (MODULO=60: 00 -> 59). enout fires on enin & V == 0 (borrow). Load and clear are unchanged.
- Undefined: dir is ignored and up-only logic is synthesised; the dir port remains for interface stability.

Test Plan:
- MODULO=60, rst 1 cycle then enin=1 for 60 cycles -> ones/tens step 00..59 then 00; enout high only in the cycle V=59; wrap high the cycle after.
- MODULO=24, load 2/3 then enin one cycle -> V=23 then 00; enout=1 during the 23 cycle; mod-60 to mod-60 to mod-24 chain rolls 23:59:59 -> 00:00:00 in one edge.
- MODULO=60, load ld_tens=6, ld_ones=0 -> V=00, load_err=1 for one cycle; load ld_ones=4'hA -> same; load 4/5 -> V=45, load_err=0.
- V=59, enin=1 and load=1 (preset 12) in the same cycle -> V=12, enout=0, wrap=0; enin=1 and clr=1 -> V=INIT_VAL, enout=0.
- Mid-count rst while enin=1 at V=37 -> V=INIT_VAL next cycle, wrap=0, load_err=0.
- BCD_CNT_DOWN_EN, MODULO=60, V=01, dir=1, enin 2 cycles -> 00 then 59; enout=1 in the 00 cycle; without the macro the same stimulus -> 02, 03.

Source files
------------

// File: rtl/bcd_modn_cnt_if.sv
// Control and digit bus of one bcd_modn_cnt stage.
// The master drives the count/clear/preset controls; the counter drives the digits and pulses.
interface bcd_modn_cnt_if;
  logic       clr;
  logic       enin;
  logic       dir;
  logic       load;
  logic [3:0] ld_ones;
  logic [3:0] ld_tens;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       enout;
  logic       wrap;
  logic       load_err;

  modport master (
    output clr, enin, dir, load, ld_ones, ld_tens,
    input  ones, tens, enout, wrap, load_err
  );

  modport slave (
    input  clr, enin, dir, load, ld_ones, ld_tens,
    output ones, tens, enout, wrap, load_err
  );
endinterface

// File: rtl/bcd_modn_cnt.sv
// Two-digit BCD modulo-N counter stage with preset load, wrap pulse and carry chaining.
// Optional count-down direction is enabled by defining BCD_CNT_DOWN_EN.
module bcd_modn_cnt #(
  parameter int MODULO   = 60,
  parameter int INIT_VAL = 0
) (
  input logic             clk,
  input logic             rst,
  bcd_modn_cnt_if.slave   bus
);

  generate
    if (MODULO < 2 || MODULO > 100 || INIT_VAL < 0 || INIT_VAL >= MODULO) begin : g_bad_param
      $error("bcd_modn_cnt: MODULO must be 2..100 and INIT_VAL 0..MODULO-1");
    end
  endgenerate

  localparam logic [6:0] TERM_UP = 7'(MODULO - 1);
  localparam logic [7:0] MOD8    = 8'(MODULO);
  localparam logic [3:0] INIT_T  = 4'(INIT_VAL / 10);
  localparam logic [3:0] INIT_O  = 4'(INIT_VAL % 10);
  localparam logic [3:0] MAX_T   = 4'((MODULO - 1) / 10);
  localparam logic [3:0] MAX_O   = 4'((MODULO - 1) % 10);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       wrap_q, wrap_d;
  logic       err_q,  err_d;
  logic [6:0] val;
  logic [7:0] ld_val;
  logic       ld_ok;
  logic       down;
  logic       term_hit;
  logic       enout;

`ifdef BCD_CNT_DOWN_EN
  assign down = bus.dir;
`else
  logic unused_dir;
  assign down       = 1'b0;
  assign unused_dir = bus.dir;
`endif

  // Terminal detection works on the full binary value so moduli like 24 wrap at 23, not at a ones 9.
  assign val      = 7'(tens_q) * 7'd10 + 7'(ones_q);
  assign ld_val   = 8'(bus.ld_tens) * 8'd10 + 8'(bus.ld_ones);
  assign ld_ok    = (bus.ld_ones <= 4'd9) && (bus.ld_tens <= 4'd9) && (ld_val < MOD8);
  assign term_hit = down ? (val == 7'd0) : (val == TERM_UP);
  assign enout    = bus.enin & ~rst & ~bus.clr & ~bus.load & term_hit;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (bus.clr) begin
      ones_d = INIT_O;
      tens_d = INIT_T;
    end else if (bus.load) begin
      ones_d = ld_ok ? bus.ld_ones : 4'd0;
      tens_d = ld_ok ? bus.ld_tens : 4'd0;
      err_d  = ~ld_ok;
    end else if (bus.enin) begin
      wrap_d = enout;
      if (down) begin
        if (term_hit) begin
          ones_d = MAX_O;
          tens_d = MAX_T;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end else begin
        if (term_hit) begin
          ones_d = 4'd0;
          tens_d = 4'd0;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= INIT_O;
      tens_q <= INIT_T;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.ones     = ones_q;
  assign bus.tens     = tens_q;
  assign bus.enout    = enout;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_modn_cnt.sv
// Bench for bcd_modn_cnt: standalone mod-60 and mod-24 stages plus an hh:mm:ss chain,
// each compared against an integer-arithmetic model.
module tb_bcd_modn_cnt;

`ifdef BCD_CNT_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_modn_cnt_if b60 ();
  bcd_modn_cnt_if b24 ();
  bcd_modn_cnt_if bs ();
  bcd_modn_cnt_if bm ();
  bcd_modn_cnt_if bh ();

  bcd_modn_cnt #(.MODULO(60), .INIT_VAL(0)) u60 (.clk(clk), .rst(rst), .bus(b60.slave));
  bcd_modn_cnt #(.MODULO(24), .INIT_VAL(5)) u24 (.clk(clk), .rst(rst), .bus(b24.slave));
  bcd_modn_cnt #(.MODULO(60), .INIT_VAL(0)) us  (.clk(clk), .rst(rst), .bus(bs.slave));
  bcd_modn_cnt #(.MODULO(60), .INIT_VAL(0)) um  (.clk(clk), .rst(rst), .bus(bm.slave));
  bcd_modn_cnt #(.MODULO(24), .INIT_VAL(0)) uh  (.clk(clk), .rst(rst), .bus(bh.slave));

  assign bm.enin = bs.enout;
  assign bh.enin = bm.enout;

  int ntests = 0;
  int nfail  = 0;
  int m60, m24, tsec;

  function automatic bit ld_ok(int md, int lt, int lo);
    return lt <= 9 && lo <= 9 && lt * 10 + lo < md;
  endfunction

  function automatic int nxt(int v, int md, int ini, bit c, bit l, int lt, int lo, bit en, bit dn);
    if (c) return ini;
    if (l) return ld_ok(md, lt, lo) ? lt * 10 + lo : 0;
    if (en) return dn ? (v + md - 1) % md : (v + 1) % md;
    return v;
  endfunction

  function automatic bit cry(int v, int md, bit c, bit l, bit en, bit dn);
    return en && !c && !l && (v == (dn ? 0 : md - 1));
  endfunction

  task automatic set60(bit c, bit l, bit en, bit d, int lt, int lo);
    b60.clr = c; b60.load = l; b60.enin = en; b60.dir = d;
    b60.ld_tens = 4'(lt); b60.ld_ones = 4'(lo);
  endtask

  task automatic set24(bit c, bit l, bit en, int lt, int lo);
    b24.clr = c; b24.load = l; b24.enin = en; b24.dir = 1'b0;
    b24.ld_tens = 4'(lt); b24.ld_ones = 4'(lo);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set60(0, 0, 1, 0, 0, 0);
    set24(0, 0, 1, 0, 0);
    #2;
    ntests++;
    if (b60.enout !== 1'b0) begin
      nfail++; $display("FAIL reset_enout: got %b want 0", b60.enout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m60 = 0; m24 = 5; tsec = 0;
    ntests++;
    if ({b60.tens, b60.ones, b60.wrap, b60.load_err} !== {8'h00, 2'b00}) begin
      nfail++; $display("FAIL reset_u60: got %0d%0d w%b e%b want 00 w0 e0",
                        b60.tens, b60.ones, b60.wrap, b60.load_err);
    end
    ntests++;
    if ({b24.tens, b24.ones, b24.wrap, b24.load_err} !== {8'h05, 2'b00}) begin
      nfail++; $display("FAIL reset_u24: got %0d%0d w%b e%b want 05 w0 e0",
                        b24.tens, b24.ones, b24.wrap, b24.load_err);
    end
    ntests++;
    if ({bh.tens, bh.ones, bm.tens, bm.ones, bs.tens, bs.ones} !== 24'h0) begin
      nfail++; $display("FAIL reset_chain: got %0d%0d:%0d%0d:%0d%0d want 00:00:00",
                        bh.tens, bh.ones, bm.tens, bm.ones, bs.tens, bs.ones);
    end
  endtask

  task automatic test_count_up();
    bit ec;
    set60(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 61; i++) begin
      #2;
      ec = cry(m60, 60, 0, 0, 1, 0);
      ntests++;
      if (b60.enout !== ec) begin
        nfail++; $display("FAIL up_enout[%0d]: got %b want %b", i, b60.enout, ec);
      end
      @(posedge clk); #1;
      m60 = nxt(m60, 60, 0, 0, 0, 0, 0, 1, 0);
      ntests++;
      if ({b60.tens, b60.ones, b60.wrap} !== {4'(m60 / 10), 4'(m60 % 10), ec}) begin
        nfail++; $display("FAIL up_value[%0d]: got %0d%0d w%b want %0d w%b",
                          i, b60.tens, b60.ones, b60.wrap, m60, ec);
      end
    end
  endtask

  task automatic test_load();
    int lt_tab [6] = '{6, 0, 4, 9, 5, 15};
    int lo_tab [6] = '{0, 10, 5, 9, 9, 3};
    bit ee;
    for (int i = 0; i < 6; i++) begin
      set60(0, 1, 0, 0, lt_tab[i], lo_tab[i]);
      @(posedge clk); #1;
      m60 = nxt(m60, 60, 0, 0, 1, lt_tab[i], lo_tab[i], 0, 0);
      ee  = !ld_ok(60, lt_tab[i], lo_tab[i]);
      ntests++;
      if ({b60.tens, b60.ones, b60.load_err, b60.wrap} !== {4'(m60 / 10), 4'(m60 % 10), ee, 1'b0}) begin
        nfail++; $display("FAIL load[%0d]: got %0d%0d e%b want %0d e%b",
                          i, b60.tens, b60.ones, b60.load_err, m60, ee);
      end
      set60(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      ntests++;
      if ({b60.tens, b60.ones, b60.load_err} !== {4'(m60 / 10), 4'(m60 % 10), 1'b0}) begin
        nfail++; $display("FAIL load_hold[%0d]: got %0d%0d e%b want %0d e0",
                          i, b60.tens, b60.ones, b60.load_err, m60);
      end
    end
  endtask

  task automatic test_priority();
    set60(0, 1, 0, 0, 5, 9);
    @(posedge clk); #1;
    set60(0, 1, 1, 0, 1, 2);
    #2;
    ntests++;
    if (b60.enout !== 1'b0) begin
      nfail++; $display("FAIL prio_load_enout: got %b want 0", b60.enout);
    end
    @(posedge clk); #1;
    ntests++;
    if ({b60.tens, b60.ones, b60.wrap} !== {8'h12, 1'b0}) begin
      nfail++; $display("FAIL prio_load: got %0d%0d w%b want 12 w0", b60.tens, b60.ones, b60.wrap);
    end
    set60(0, 1, 0, 0, 5, 9);
    @(posedge clk); #1;
    set60(1, 1, 1, 0, 3, 3);
    #2;
    ntests++;
    if (b60.enout !== 1'b0) begin
      nfail++; $display("FAIL prio_clr_enout: got %b want 0", b60.enout);
    end
    @(posedge clk); #1;
    m60 = 0;
    ntests++;
    if ({b60.tens, b60.ones, b60.wrap, b60.load_err} !== {8'h00, 2'b00}) begin
      nfail++; $display("FAIL prio_clr: got %0d%0d w%b e%b want 00 w0 e0",
                        b60.tens, b60.ones, b60.wrap, b60.load_err);
    end
    set60(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_mid_reset();
    int lt_tab [2] = '{3, 5};
    int lo_tab [2] = '{7, 9};
    for (int i = 0; i < 2; i++) begin
      set60(0, 1, 0, 0, lt_tab[i], lo_tab[i]);
      @(posedge clk); #1;
      set60(0, 0, 1, 0, 0, 0);
      rst = 1'b1;
      #2;
      ntests++;
      if (b60.enout !== 1'b0) begin
        nfail++; $display("FAIL midrst_enout[%0d]: got %b want 0", i, b60.enout);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      m60 = 0; m24 = 5; tsec = 0;
      ntests++;
      if ({b60.tens, b60.ones, b60.wrap, b60.load_err} !== {8'h00, 2'b00}) begin
        nfail++; $display("FAIL midrst[%0d]: got %0d%0d w%b e%b want 00 w0 e0",
                          i, b60.tens, b60.ones, b60.wrap, b60.load_err);
      end
    end
    set60(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_mod24();
    bit c_tab [5]  = '{0, 0, 0, 0, 1};
    bit l_tab [5]  = '{1, 0, 0, 1, 0};
    bit e_tab [5]  = '{0, 1, 0, 0, 1};
    int lt_tab [5] = '{2, 0, 0, 2, 0};
    int lo_tab [5] = '{3, 0, 0, 4, 0};
    bit ec, ew, ee;
    ew = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set24(c_tab[i], l_tab[i], e_tab[i], lt_tab[i], lo_tab[i]);
      #2;
      ec = cry(m24, 24, c_tab[i], l_tab[i], e_tab[i], 0);
      ntests++;
      if (b24.enout !== ec) begin
        nfail++; $display("FAIL m24_enout[%0d]: got %b want %b", i, b24.enout, ec);
      end
      @(posedge clk); #1;
      ee  = !c_tab[i] && l_tab[i] && !ld_ok(24, lt_tab[i], lo_tab[i]);
      m24 = nxt(m24, 24, 5, c_tab[i], l_tab[i], lt_tab[i], lo_tab[i], e_tab[i], 0);
      ntests++;
      if ({b24.tens, b24.ones, b24.wrap, b24.load_err} !== {4'(m24 / 10), 4'(m24 % 10), ec, ee}) begin
        nfail++; $display("FAIL m24[%0d]: got %0d%0d w%b e%b want %0d w%b e%b",
                          i, b24.tens, b24.ones, b24.wrap, b24.load_err, m24, ec, ee);
      end
    end
    set24(0, 0, 0, 0, 0);
  endtask

  task automatic test_chain();
    bit en, ec;
    bs.clr = 0; bm.clr = 0; bh.clr = 0;
    bs.dir = 0; bm.dir = 0; bh.dir = 0;
    bs.enin = 0;
    bs.load = 1; bm.load = 1; bh.load = 1;
    bs.ld_tens = 4'd5; bs.ld_ones = 4'd9;
    bm.ld_tens = 4'd5; bm.ld_ones = 4'd9;
    bh.ld_tens = 4'd2; bh.ld_ones = 4'd3;
    @(posedge clk); #1;
    bs.load = 0; bm.load = 0; bh.load = 0;
    tsec = 86399;
    for (int i = 0; i < 150; i++) begin
      en = (i == 0) || ($urandom % 4 != 0);
      if (i == 40) begin
        bs.load = 1; bm.load = 1; bh.load = 1;
        bs.ld_tens = 4'd5; bs.ld_ones = 4'd7;
        @(posedge clk); #1;
        bs.load = 0; bm.load = 0; bh.load = 0;
        tsec = 86397;
      end
      bs.enin = en;
      #2;
      ec = en && tsec == 86399;
      ntests++;
      if (bh.enout !== ec) begin
        nfail++; $display("FAIL chain_enout[%0d]: got %b want %b", i, bh.enout, ec);
      end
      @(posedge clk); #1;
      if (en) tsec = (tsec + 1) % 86400;
      ntests++;
      if ({bh.tens, bh.ones, bm.tens, bm.ones, bs.tens, bs.ones, bh.wrap} !==
          {4'(tsec / 36000), 4'((tsec / 3600) % 10), 4'((tsec % 3600) / 600),
           4'((tsec / 60) % 10), 4'((tsec % 60) / 10), 4'(tsec % 10), ec}) begin
        nfail++; $display("FAIL chain[%0d]: got %0d%0d:%0d%0d:%0d%0d w%b want %0d s w%b", i,
                          bh.tens, bh.ones, bm.tens, bm.ones, bs.tens, bs.ones, bh.wrap, tsec, ec);
      end
    end
    bs.enin = 0;
  endtask

  task automatic test_down();
    bit ec;
    set60(0, 1, 0, 0, 0, 1);
    @(posedge clk); #1;
    m60 = 1;
    set60(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #2;
      ec = cry(m60, 60, 0, 0, 1, DOWN_EN);
      ntests++;
      if (b60.enout !== ec) begin
        nfail++; $display("FAIL down_enout[%0d]: got %b want %b", i, b60.enout, ec);
      end
      @(posedge clk); #1;
      m60 = nxt(m60, 60, 0, 0, 0, 0, 0, 1, DOWN_EN);
      ntests++;
      if ({b60.tens, b60.ones, b60.wrap} !== {4'(m60 / 10), 4'(m60 % 10), ec}) begin
        nfail++; $display("FAIL down[%0d]: got %0d%0d w%b want %0d w%b",
                          i, b60.tens, b60.ones, b60.wrap, m60, ec);
      end
    end
    set60(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit c, l, en, d, ec, ee;
    int lt, lo;
    for (int i = 0; i < 400; i++) begin
      c  = ($urandom % 16 == 0);
      l  = ($urandom % 5 == 0);
      en = ($urandom % 3 != 0);
      d  = $urandom % 2;
      lt = ($urandom % 4 == 0) ? 5 : $urandom_range(0, 11);
      lo = ($urandom % 4 == 0) ? 9 : $urandom_range(0, 11);
      set60(c, l, en, d, lt, lo);
      #2;
      ec = cry(m60, 60, c, l, en, DOWN_EN && d);
      ntests++;
      if (b60.enout !== ec) begin
        nfail++; $display("FAIL rnd_enout[%0d]: got %b want %b (V=%0d)", i, b60.enout, ec, m60);
      end
      @(posedge clk); #1;
      ee  = !c && l && !ld_ok(60, lt, lo);
      m60 = nxt(m60, 60, 0, c, l, lt, lo, en, DOWN_EN && d);
      ntests++;
      if ({b60.tens, b60.ones, b60.wrap, b60.load_err} !== {4'(m60 / 10), 4'(m60 % 10), ec, ee}) begin
        nfail++; $display("FAIL rnd[%0d]: got %0d%0d w%b e%b want %0d w%b e%b",
                          i, b60.tens, b60.ones, b60.wrap, b60.load_err, m60, ec, ee);
      end
    end
    set60(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    set60(0, 0, 0, 0, 0, 0);
    set24(0, 0, 0, 0, 0);
    bs.clr = 0; bs.load = 0; bs.enin = 0; bs.dir = 0; bs.ld_tens = 0; bs.ld_ones = 0;
    bm.clr = 0; bm.load = 0; bm.dir = 0; bm.ld_tens = 0; bm.ld_ones = 0;
    bh.clr = 0; bh.load = 0; bh.dir = 0; bh.ld_tens = 0; bh.ld_ones = 0;
    #1;
    test_reset();
    test_count_up();
    test_load();
    test_priority();
    test_mid_reset();
    test_mod24();
    test_chain();
    test_down();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
